// File: rtl/stack_pkg.sv
// Shared types and constants for the stack-machine operation sequencer.
package stack_pkg;

    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned WIDTH_DEF = 8;

    localparam int unsigned ERR_UNDER   = 0;
    localparam int unsigned ERR_OVER    = 1;
    localparam int unsigned ERR_ILLEGAL = 2;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_PUSH = 4'h1,
        OP_POP  = 4'h2,
        OP_OUT  = 4'h3,
        OP_DUP  = 4'h4,
        OP_SWAP = 4'h5,
        OP_ADD  = 4'h6,
        OP_SUB  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWAP2,
        ST_OUT_WAIT
    } state_e;

endpackage

// File: rtl/stack_exec_if.sv
// Operation, stack-port and output-byte signals of the sequencer; master is the sequencer side.
interface stack_exec_if
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] op_imm;
    logic [WIDTH-1:0] stk_wr_data;
    logic             stk_wr_en;
    logic             stk_re_en_a;
    logic             stk_re_en_b;
    logic [WIDTH-1:0] stk_data_a;
    logic [WIDTH-1:0] stk_data_b;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       depth;
    logic [2:0]       err;

    modport master (
        input  op_valid, op_code, op_imm, stk_data_a, stk_data_b, out_ready,
        output op_ready, stk_wr_data, stk_wr_en, stk_re_en_a, stk_re_en_b,
               out_data, out_valid, depth, err
    );

    modport slave (
        output op_valid, op_code, op_imm, stk_data_a, stk_data_b, out_ready,
        input  op_ready, stk_wr_data, stk_wr_en, stk_re_en_a, stk_re_en_b,
               out_data, out_valid, depth, err
    );
endinterface

// File: rtl/stack_alu.sv
// Combinational ALU on the top two stack entries; a is second-from-top, b is top.
module stack_alu
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o
);
    always_comb begin
        result_o = b_i;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: result_o = b_i;
        endcase
    end
endmodule

// File: rtl/stack_exec.sv
// Stack-machine operation sequencer: decodes one op per handshake into stack enables,
// mirrors the stack depth, records sticky errors and owns the output byte register.
module stack_exec
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input logic          clock,
    input logic          reset_n,
    stack_exec_if.master bus
);
    localparam logic [3:0] FULL = 4'(DEPTH);

    state_e           state_q;
    logic [3:0]       depth_q, depth_d;
    logic [2:0]       err_q, err_set;
    logic [WIDTH-1:0] swap_q, out_data_q, wr_data, alu_res;
    logic             out_valid_q;
    logic             accept, wr_en, re_a, re_b, do_out, do_swap;
    logic             has1, has2, full;
    op_e              op;

    assign op     = op_e'(bus.op_code);
    assign accept = bus.op_valid && (state_q == ST_IDLE);
    assign has1   = (depth_q != 4'd0);
    assign has2   = (depth_q >= 4'd2);
    assign full   = (depth_q >= FULL);

    stack_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i     (op),
        .a_i      (bus.stk_data_a),
        .b_i      (bus.stk_data_b),
        .result_o (alu_res)
    );

    always_comb begin
        wr_en   = 1'b0;
        re_a    = 1'b0;
        re_b    = 1'b0;
        wr_data = alu_res;
        err_set = '0;
        do_out  = 1'b0;
        do_swap = 1'b0;
        if (state_q == ST_SWAP2) begin
            wr_en   = 1'b1;
            wr_data = swap_q;
        end else if (accept) begin
            case (op)
                OP_NOP: ;
                OP_PUSH: begin
                    if (full) err_set[ERR_OVER] = 1'b1;
                    else begin
                        wr_en   = 1'b1;
                        wr_data = bus.op_imm;
                    end
                end
                OP_POP: begin
                    if (has1) re_b = 1'b1;
                    else      err_set[ERR_UNDER] = 1'b1;
                end
                OP_OUT: begin
                    if (has1) begin
                        re_b   = 1'b1;
                        do_out = 1'b1;
                    end else err_set[ERR_UNDER] = 1'b1;
                end
                OP_DUP: begin
                    if (!has1)    err_set[ERR_UNDER] = 1'b1;
                    else if (full) err_set[ERR_OVER] = 1'b1;
                    else begin
                        wr_en   = 1'b1;
                        wr_data = bus.stk_data_b;
                    end
                end
                // SWAP pops both and pushes old top now; old second goes back in SWAP2
                OP_SWAP: begin
                    if (has2) begin
                        re_a    = 1'b1;
                        re_b    = 1'b1;
                        wr_en   = 1'b1;
                        wr_data = bus.stk_data_b;
                        do_swap = 1'b1;
                    end else err_set[ERR_UNDER] = 1'b1;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    if (has2) begin
                        re_a  = 1'b1;
                        re_b  = 1'b1;
                        wr_en = 1'b1;
                    end else err_set[ERR_UNDER] = 1'b1;
                end
                default: err_set[ERR_ILLEGAL] = 1'b1;
            endcase
        end
        depth_d = depth_q + {3'b000, wr_en} - {3'b000, re_a} - {3'b000, re_b};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            depth_q     <= '0;
            err_q       <= '0;
            swap_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_q | err_set;
            case (state_q)
                ST_IDLE: begin
                    if (do_swap) begin
                        swap_q  <= bus.stk_data_a;
                        state_q <= ST_SWAP2;
                    end else if (do_out) begin
                        out_data_q  <= bus.stk_data_b;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT_WAIT;
                    end
                end
                ST_SWAP2: state_q <= ST_IDLE;
                ST_OUT_WAIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.op_ready    = (state_q == ST_IDLE);
    assign bus.stk_wr_en   = wr_en;
    assign bus.stk_re_en_a = re_a;
    assign bus.stk_re_en_b = re_b;
    assign bus.stk_wr_data = wr_data;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.depth       = depth_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_stack_exec.sv
// Bench for stack_exec: behavioural stack on the stack port, queue-based reference model.
module tb_stack_exec;
    logic clock;
    logic reset_n;

    stack_exec_if #(.WIDTH(8)) bus ();

    stack_exec #(.DEPTH(8), .WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stack device: pops requested entries, then pushes write data on the same edge.
    logic [7:0] smem [8];
    int         scnt;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scnt <= 0;
        end else begin
            if (bus.stk_wr_en) begin
                if ((scnt - int'(bus.stk_re_en_a) - int'(bus.stk_re_en_b)) inside {[0:7]})
                    smem[scnt - int'(bus.stk_re_en_a) - int'(bus.stk_re_en_b)] <= bus.stk_wr_data;
            end
            scnt <= scnt - int'(bus.stk_re_en_a) - int'(bus.stk_re_en_b) + int'(bus.stk_wr_en);
        end
    end

    always_comb begin
        bus.stk_data_a = 8'h00;
        bus.stk_data_b = 8'h00;
        if (scnt >= 1 && scnt <= 8) bus.stk_data_b = smem[scnt-1];
        if (scnt >= 2 && scnt <= 8) bus.stk_data_a = smem[scnt-2];
    end

    // Reference model
    logic [7:0] rq[$];
    logic [2:0] rerr;
    int unsigned vectors;
    int unsigned miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] code, input logic [7:0] imm);
        int unsigned sz;
        int unsigned n;
        logic [7:0]  a, b, r;
        logic [7:0]  exp_out;
        logic        is_out, is_swap;
        n = 0;
        while (!bus.op_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("op_ready_before", {31'b0, bus.op_ready}, 32'd1);
        sz      = rq.size();
        is_out  = 1'b0;
        is_swap = 1'b0;
        exp_out = 8'h00;
        case (code)
            4'h0: ;
            4'h1: if (sz < 8) rq.push_back(imm); else rerr[1] = 1'b1;
            4'h2: if (sz >= 1) void'(rq.pop_back()); else rerr[0] = 1'b1;
            4'h3: if (sz >= 1) begin exp_out = rq.pop_back(); is_out = 1'b1; end
                  else rerr[0] = 1'b1;
            4'h4: if (sz == 0) rerr[0] = 1'b1;
                  else if (sz >= 8) rerr[1] = 1'b1;
                  else rq.push_back(rq[sz-1]);
            4'h5: if (sz >= 2) begin
                      b = rq.pop_back(); a = rq.pop_back();
                      rq.push_back(b); rq.push_back(a);
                      is_swap = 1'b1;
                  end else rerr[0] = 1'b1;
            4'h6, 4'h7, 4'h8, 4'h9, 4'hA: if (sz >= 2) begin
                      b = rq.pop_back(); a = rq.pop_back();
                      case (code)
                          4'h6:    r = 8'((int'(a) + int'(b)) % 256);
                          4'h7:    r = 8'((int'(a) - int'(b) + 256) % 256);
                          4'h8:    r = a & b;
                          4'h9:    r = a | b;
                          default: r = a ^ b;
                      endcase
                      rq.push_back(r);
                  end else rerr[0] = 1'b1;
            default: rerr[2] = 1'b1;
        endcase
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_imm   = imm;
        @(posedge clock); #1;
        bus.op_valid = 1'b0;
        if (is_swap) begin
            chk("swap_busy", {31'b0, bus.op_ready}, 32'd0);
            @(posedge clock); #1;
            chk("swap_done", {31'b0, bus.op_ready}, 32'd1);
        end
        if (is_out) begin
            chk("out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("out_data", {24'b0, bus.out_data}, {24'b0, exp_out});
            chk("out_busy", {31'b0, bus.op_ready}, 32'd0);
        end
        chk("depth", {28'b0, bus.depth}, rq.size());
        chk("err", {29'b0, bus.err}, {29'b0, rerr});
        if (is_out && bus.out_ready) begin
            @(posedge clock); #1;
            chk("out_release", {30'b0, bus.out_valid, bus.op_ready}, 32'd1);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rerr         = '0;
        reset_n      = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = 4'h0;
        bus.op_imm   = 8'h00;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_depth", {28'b0, bus.depth}, 32'd0);
        chk("rst_err", {29'b0, bus.err}, 32'd0);
        chk("rst_out", {23'b0, bus.out_valid, bus.out_data}, 32'd0);
        chk("rst_ready", {31'b0, bus.op_ready}, 32'd1);
        chk("rst_en", {29'b0, bus.stk_wr_en, bus.stk_re_en_a, bus.stk_re_en_b}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        do_op(4'h1, 8'd3); do_op(4'h1, 8'd5); do_op(4'h6, 8'd0); do_op(4'h3, 8'd0);
        do_op(4'h1, 8'd9); do_op(4'h1, 8'd4); do_op(4'h7, 8'd0); do_op(4'h3, 8'd0);
        do_op(4'h1, 8'd4); do_op(4'h1, 8'd9); do_op(4'h7, 8'd0); do_op(4'h3, 8'd0);
        do_op(4'h1, 8'd1); do_op(4'h1, 8'd2); do_op(4'h5, 8'd0);
        do_op(4'h3, 8'd0); do_op(4'h3, 8'd0);

        // Output stall: consumer holds out_ready low for four cycles
        do_op(4'h1, 8'h5A);
        bus.out_ready = 1'b0;
        do_op(4'h3, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("stall_data", {24'b0, bus.out_data}, 32'h5A);
            chk("stall_ready", {31'b0, bus.op_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        chk("stall_release", {30'b0, bus.out_valid, bus.op_ready}, 32'd1);

        for (int i = 0; i < 9; i++) do_op(4'h1, 8'(i + 16));
        chk("full_err", {29'b0, bus.err}, 32'd2);
        chk("full_depth", {28'b0, bus.depth}, 32'd8);
        for (int i = 0; i < 9; i++) do_op(4'h2, 8'd0);
        chk("empty_err", {29'b0, bus.err}, 32'd3);
        do_op(4'hC, 8'd0);
        chk("final_err", {29'b0, bus.err}, 32'd7);

        // Reset asserted during the SWAP2 cycle
        do_op(4'h1, 8'd7); do_op(4'h1, 8'd8);
        bus.op_valid = 1'b1;
        bus.op_code  = 4'h5;
        @(posedge clock); #1;
        bus.op_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        rq.delete();
        rerr = '0;
        chk("mid_rst_depth", {28'b0, bus.depth}, 32'd0);
        chk("mid_rst_err", {29'b0, bus.err}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.op_ready}, 32'd1);
        chk("mid_rst_wr", {31'b0, bus.stk_wr_en}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            logic [3:0] c;
            if ($urandom_range(0, 99) < 35) c = 4'h1;
            else c = 4'($urandom_range(0, 15));
            do_op(c, 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stack_exec.md
# stack_exec

Operation sequencer that drives the 8-entry, 8-bit operand stack from the initiator side. It accepts one stack-machine operation per handshake, issues the matching push/pop enables and write data to the stack, and computes ALU results from the top two entries. It tracks stack depth internally and rejects operations that would underflow or overflow. It sits between instruction fetch/decode and the stack, and owns the output byte port.

## Interface
Parameters:
- DEPTH, 8: stack capacity in entries. Must match the stack instance.
- WIDTH, 8: data width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- op_valid  in  1  operation offered
- op_ready  out  1  operation accepted this cycle when op_valid && op_ready
- op_code  in  4  opcode (stack_pkg::op_e)
- op_imm  in  8  immediate for PUSH
- stk_wr_data  out  8  data to stack write port
- stk_wr_en  out  1  push / write enable
- stk_re_en_a  out  1  pop second-from-top
- stk_re_en_b  out  1  pop top
- stk_data_a  in  8  second-from-top (combinational from stack)
- stk_data_b  in  8  top of stack
- out_data  out  8  byte produced by OUT
- out_valid  out  1  out_data valid; held until out_ready
- out_ready  in  1  consumer accepts out_data
- depth  out  4  current entry count, 0..8
- err  out  3  sticky flags: [0] underflow, [1] overflow, [2] illegal opcode

## Operation
- States: IDLE, SWAP2, OUT_WAIT. op_ready = (state == IDLE).
- Operations execute combinationally in the accept cycle. Stack enables are asserted only in that cycle, plus the SWAP2 cycle.
- In the table below, a = stk_data_a and b = stk_data_b. Each entry gives the requirement, the enables, and the depth change.
  - NOP 0: nothing.
  - PUSH 1: depth<8; wr_en, wr_data=op_imm; +1.
  - POP 2: depth>=1; re_en_b; -1.
  - OUT 3: depth>=1; re_en_b; capture b into out_data, out_valid=1; go to OUT_WAIT; -1.
  - DUP 4: 1<=depth<8; wr_en, wr_data=b; +1.
  - SWAP 5: depth>=2.
    - Cycle 1: re_en_a, re_en_b, wr_en, wr_data=b. Latch a. Go to SWAP2.
    - SWAP2: wr_en, wr_data=latched a. Return to IDLE. Net change 0.
  - ADD 6 / SUB 7 / AND 8 / OR 9 / XOR A: depth>=2; re_en_a, re_en_b, wr_en; wr_data = a op b (SUB = a - b); -1.
- Arithmetic is modulo 2^8; carry and borrow are discarded.
- Opcodes B..F are illegal. They set err[2], are consumed, and assert no enables.
- A failed depth check sets err[0] or err[1], consumes the op, and asserts no enables. Depth is unchanged.
- Errors never block further operations. Err bits clear only on reset.
- OUT_WAIT: out_valid held with out_data stable. Return to IDLE on the cycle out_valid && out_ready.

## Timing
- Reset (async assert, release synchronised externally):
  - state=IDLE, depth=0, err=0.
  - out_valid=0, out_data=0, SWAP latch=0.
  - All stack enables 0.
- The stack must be reset from the same source so that its count matches depth.
- Single-cycle ops: the accepting edge updates the stack and depth. The next op can be accepted on the following cycle.
- SWAP: op_ready is low for exactly 1 cycle after acceptance.
- OUT: op_ready is low from the accept edge until the out_ready handshake edge. The minimum is 1 cycle, if out_ready is already high.
- Depth boundaries:
  - depth=8: PUSH and DUP fail.
  - depth=0: POP, OUT and DUP fail.
  - depth=1: SWAP and ALU ops fail.
- Reset asserted mid-SWAP or in OUT_WAIT: the pending write or output is abandoned and state returns to IDLE immediately.
- Stack enables are purely combinational from state, the handshake and depth. There is no registered delay.

## Structure
- stack_pkg holds:
  - op_e enum (4-bit, values above)
  - state_e enum
  - DEPTH and WIDTH defaults
  - ERR_UNDER/ERR_OVER/ERR_ILLEGAL bit indices
- Sub-module stack_alu: combinational (op, a, b) -> result. Shared with any future flag logic.
- stack_exec contains the FSM, the depth mirror, the error logic and the output register.

## Test plan
- PUSH 3, PUSH 5, ADD, OUT with out_ready=1 -> out_data=8, depth 2,1,0 across ops, err=0.
- PUSH 9, PUSH 4, SUB, OUT; then PUSH 4, PUSH 9, SUB, OUT -> outputs 5 then 251 (0xFB).
- PUSH 1, PUSH 2, SWAP, OUT, OUT -> op_ready low one cycle after SWAP; outputs 1 then 2; depth ends 0.
- OUT with out_ready held low 4 cycles -> out_valid high and out_data stable for 4 cycles, op_ready low throughout; releases on handshake.
- 9 PUSHes, then POP on empty after 8 POPs, then opcode 0xC:
  - 9th PUSH sets err[1] with depth staying 8.
  - The extra POP sets err[0].
  - 0xC sets err[2].
  - Final err=3'b111.
- PUSH 7, PUSH 8, SWAP, assert reset_n=0 in the SWAP2 cycle -> depth=0, state IDLE, no stk_wr_en after reset, err=0.
